// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with early completion for divide-by-zero and signed overflow.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Flush,
    input  logic [2:0]  MDUctrl,
    input  logic [31:0] MDUop1,
    input  logic [31:0] MDUop2,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  ctrl;
    logic [31:0] src1, src2;
    logic [31:0] opnd;
    logic [31:0] hi, lo;
    logic [5:0]  cnt;
    logic        negMain, negRem;
    logic [31:0] result;

    logic        isDiv, divSigned, signed1, signed2, neg1, neg2;
    logic [31:0] mag1, mag2;
    logic        divZero, overflow;
    logic [31:0] specialResult;

    // Operand decode from the captured request, used during PREP
    always_comb begin
        isDiv         = ctrl[2];
        divSigned     = isDiv & ~ctrl[0];
        signed1       = (ctrl == 3'b001) | (ctrl == 3'b010) | divSigned;
        signed2       = (ctrl == 3'b001) | divSigned;
        neg1          = signed1 & src1[31];
        neg2          = signed2 & src2[31];
        mag1          = neg1 ? (32'd0 - src1) : src1;
        mag2          = neg2 ? (32'd0 - src2) : src2;
        divZero       = isDiv & (src2 == 32'd0);
        overflow      = divSigned & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
        specialResult = 32'd0;
        if (divZero)
            specialResult = ctrl[1] ? src1 : 32'hFFFF_FFFF;
        else
            specialResult = ctrl[1] ? 32'd0 : 32'h8000_0000;
    end

    logic [32:0] mulSum, divShift, divDiff;
    logic [31:0] stepHi, stepLo;
    logic [63:0] prod, prodAdj;
    logic [31:0] quo, rem, finalResult;

    // One iteration step; the final step's outcome is sign-corrected and registered on entry to FIN
    always_comb begin
        mulSum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
        divShift = {hi, lo[31]};
        divDiff  = divShift - {1'b0, opnd};
        if (isDiv) begin
            if (!divDiff[32]) begin
                stepHi = divDiff[31:0];
                stepLo = {lo[30:0], 1'b1};
            end else begin
                stepHi = {hi[30:0], lo[31]};
                stepLo = {lo[30:0], 1'b0};
            end
        end else begin
            stepHi = mulSum[32:1];
            stepLo = {mulSum[0], lo[31:1]};
        end
        prod    = {stepHi, stepLo};
        prodAdj = negMain ? (64'd0 - prod) : prod;
        quo     = negMain ? (32'd0 - stepLo) : stepLo;
        rem     = negRem ? (32'd0 - stepHi) : stepHi;
        if (isDiv)
            finalResult = ctrl[1] ? rem : quo;
        else
            finalResult = (ctrl[1:0] == 2'b00) ? prodAdj[31:0] : prodAdj[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ctrl    <= 3'd0;
            src1    <= 32'd0;
            src2    <= 32'd0;
            opnd    <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            cnt     <= 6'd0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            result  <= 32'd0;
        end else if (state != IDLE && Flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        ctrl  <= MDUctrl;
                        src1  <= MDUop1;
                        src2  <= MDUop2;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (divZero || overflow) begin
                        result <= specialResult;
                        state  <= FIN;
                    end else begin
                        negMain <= neg1 ^ neg2;
                        negRem  <= divSigned & src1[31];
                        cnt     <= 6'd32;
                        hi      <= 32'd0;
                        opnd    <= isDiv ? mag2 : mag1;
                        lo      <= isDiv ? mag1 : mag2;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    hi  <= stepHi;
                    lo  <= stepLo;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        result <= finalResult;
                        state  <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy   = (state != IDLE);
    assign Done   = (state == FIN);
    assign Result = result;

endmodule
